pll_lock_reset_sequencer: RTL and testbench

//   Sits directly downstream of the system PLL and is clocked by its primary 160 MHz output.

---
 rtl/pll_lock_reset_sequencer.sv | 152 +++++++++++++++
 tb/tb_pll_lock_reset_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_reset_sequencer.sv
// Staged reset release behind the system PLL: waits for a stable lock, then
// deasserts each domain reset one gap apart; any lock loss re-asserts them all.
module pll_lock_reset_sequencer #(
   parameter int LOCK_STABLE_CYCLES = 1024,
   parameter int STAGE_GAP_CYCLES   = 16,
   parameter int NUM_STAGES         = 3,
   parameter int SYNC_STAGES        = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  pll_locked,
   input  logic                  sw_reset_req,
   output logic [NUM_STAGES-1:0] rst_out_n,
   output logic                  sys_ready,
   output logic [7:0]            lock_loss_cnt,
   output logic [2:0]            seq_state
);

   localparam int CNT_MAX = (LOCK_STABLE_CYCLES > STAGE_GAP_CYCLES) ?
                            LOCK_STABLE_CYCLES : STAGE_GAP_CYCLES;
   localparam int CW = $clog2(CNT_MAX) + 1;

   // The WAIT_LOCK cycle that first sees lock counts as the first stable cycle,
   // so STABLE only needs LOCK_STABLE_CYCLES-1 more.
   localparam logic [CW-1:0] STABLE_LAST =
      CW'((LOCK_STABLE_CYCLES >= 2) ? LOCK_STABLE_CYCLES - 2 : 0);
   localparam logic [CW-1:0] GAP_LAST = CW'(STAGE_GAP_CYCLES - 1);
   localparam logic [NUM_STAGES-1:0] FIRST_REL = NUM_STAGES'(1);
   localparam logic [NUM_STAGES-1:0] ALL_REL   = {NUM_STAGES{1'b1}};

   typedef enum logic [2:0] {
      WAIT_LOCK = 3'd0,
      STABLE    = 3'd1,
      RELEASE   = 3'd2,
      RUN       = 3'd3,
      HOLD      = 3'd4
   } state_t;

   localparam state_t AFTER_FIRST = (NUM_STAGES == 1) ? RUN : RELEASE;

   logic [SYNC_STAGES-1:0] sync;
   logic                   lock_s;
   logic                   lock_prev;
   state_t                 state, state_nx;
   logic [CW-1:0]          cnt, cnt_nx;
   logic [NUM_STAGES-1:0]  rst_nx, rst_shift;
   logic                   rdy_nx;

   assign lock_s    = sync[SYNC_STAGES-1];
   assign seq_state = state;
   // Next stage released = current pattern shifted up with a one filled in at bit 0
   assign rst_shift = NUM_STAGES'({rst_out_n, 1'b1});

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync          <= '0;
         lock_prev     <= 1'b0;
         lock_loss_cnt <= 8'd0;
      end else begin
         sync      <= {sync[SYNC_STAGES-2:0], pll_locked};
         lock_prev <= lock_s;
         if (lock_prev && !lock_s && lock_loss_cnt != 8'hFF)
            lock_loss_cnt <= lock_loss_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= WAIT_LOCK;
         cnt       <= '0;
         rst_out_n <= '0;
         sys_ready <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         rst_out_n <= rst_nx;
         sys_ready <= rdy_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      rst_nx   = rst_out_n;
      rdy_nx   = 1'b0;
      case (state)
         WAIT_LOCK: begin
            rst_nx = '0;
            cnt_nx = '0;
            if (lock_s) begin
               if (LOCK_STABLE_CYCLES == 1) begin
                  rst_nx   = FIRST_REL;
                  state_nx = AFTER_FIRST;
               end else begin
                  state_nx = STABLE;
               end
            end
         end
         STABLE: begin
            if (cnt == STABLE_LAST) begin
               rst_nx   = FIRST_REL;
               cnt_nx   = '0;
               state_nx = AFTER_FIRST;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         RELEASE: begin
            if (cnt == GAP_LAST) begin
               rst_nx = rst_shift;
               cnt_nx = '0;
               if (&rst_shift) state_nx = RUN;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         RUN: begin
            rst_nx = ALL_REL;
            rdy_nx = 1'b1;
            if (sw_reset_req) begin
               rst_nx   = '0;
               rdy_nx   = 1'b0;
               cnt_nx   = '0;
               state_nx = HOLD;
            end
         end
         HOLD: begin
            rst_nx = '0;
            if (cnt == GAP_LAST) begin
               rst_nx   = FIRST_REL;
               cnt_nx   = '0;
               state_nx = AFTER_FIRST;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         default: begin
            rst_nx   = '0;
            cnt_nx   = '0;
            state_nx = WAIT_LOCK;
         end
      endcase
      // Lock loss overrides everything, including a same-cycle sw_reset_req
      if (state != WAIT_LOCK && !lock_s) begin
         rst_nx   = '0;
         rdy_nx   = 1'b0;
         cnt_nx   = '0;
         state_nx = WAIT_LOCK;
      end
   end

endmodule

// File: tb/tb_pll_lock_reset_sequencer.sv
// Bench for pll_lock_reset_sequencer: directed scenarios plus random lock/sw traffic
// against a timeline model (release origin + arithmetic on edge numbers).
module tb_pll_lock_reset_sequencer;

   localparam int L = 8;
   localparam int G = 4;
   localparam int N = 3;
   localparam int S = 2;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         pll_locked = 1'b0;
   logic         sw_reset_req = 1'b0;
   logic [N-1:0] rst_out_n;
   logic         sys_ready;
   logic [7:0]   lock_loss_cnt;
   logic [2:0]   seq_state;

   pll_lock_reset_sequencer #(
      .LOCK_STABLE_CYCLES(L), .STAGE_GAP_CYCLES(G), .NUM_STAGES(N), .SYNC_STAGES(S)
   ) dut (
      .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked), .sw_reset_req(sw_reset_req),
      .rst_out_n(rst_out_n), .sys_ready(sys_ready), .lock_loss_cnt(lock_loss_cnt),
      .seq_state(seq_state)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   // Model state: sampled pll history, consecutive-lock run length, and the
   // edge number t0 at which stage 0 is (or will be) released.
   int         n;
   logic       h1, h2, prev_ls, valid;
   int         run, t0, m_cnt;
   logic [N-1:0] e_rst;
   logic       e_rdy;
   logic [7:0] e_cnt;
   logic [2:0] e_seq;

   task automatic model_reset();
      h1 = 0; h2 = 0; prev_ls = 0; valid = 0; run = 0; t0 = 0; m_cnt = 0;
      e_rst = '0; e_rdy = 0; e_cnt = 0; e_seq = 0;
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      pll_locked = 1'b0;
      sw_reset_req = 1'b0;
      model_reset();
      #1;
   endtask

   task automatic step(input logic pl, input logic sw);
      logic ls;
      pll_locked   = pl;
      sw_reset_req = sw;
      @(posedge clk);
      n++;
      ls = h2; h2 = h1; h1 = pll_locked;
      if (prev_ls && !ls && m_cnt < 255) m_cnt++;
      prev_ls = ls;
      if (!ls) begin
         valid = 0; run = 0;
      end else if (valid) begin
         if (sw_reset_req && n > t0 + (N-1)*G) t0 = n + G;
      end else begin
         run++;
         if (run >= L) begin valid = 1; t0 = n; end
      end
      for (int k = 0; k < N; k++) e_rst[k] = valid && (n >= t0 + k*G);
      e_rdy = valid && (n >= t0 + (N-1)*G + 1);
      e_cnt = 8'(m_cnt);
      if (!valid)                e_seq = (run > 0) ? 3'd1 : 3'd0;
      else if (n < t0)           e_seq = 3'd4;
      else if (n < t0 + (N-1)*G) e_seq = 3'd2;
      else                       e_seq = 3'd3;
      #1;
   endtask

   task automatic test_reset();
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         total++;
         if ({rst_out_n, sys_ready, lock_loss_cnt, seq_state} !== 15'd0) begin
            $display("FAIL reset cyc%0d: got rst=%b rdy=%b cnt=%0d st=%0d, want all 0",
                     i, rst_out_n, sys_ready, lock_loss_cnt, seq_state);
         end else passed++;
      end
   endtask

   task automatic test_powerup();
      int first_bit [N];
      int first_rdy;
      for (int k = 0; k < N; k++) first_bit[k] = -1;
      first_rdy = -1;
      reset_n = 1'b1;
      for (int e = 1; e <= 22; e++) begin
         step(1'b1, 1'b0);
         total++;
         if ({rst_out_n, sys_ready, lock_loss_cnt, seq_state} !== {e_rst, e_rdy, e_cnt, e_seq}) begin
            $display("FAIL powerup E%0d: got rst=%b rdy=%b cnt=%0d st=%0d, want rst=%b rdy=%b cnt=%0d st=%0d",
                     e, rst_out_n, sys_ready, lock_loss_cnt, seq_state, e_rst, e_rdy, e_cnt, e_seq);
         end else passed++;
         for (int k = 0; k < N; k++) if (rst_out_n[k] && first_bit[k] < 0) first_bit[k] = e;
         if (sys_ready && first_rdy < 0) first_rdy = e;
      end
      total++;
      if (first_bit[0] != 10 || first_bit[1] != 14 || first_bit[2] != 18 || first_rdy != 19) begin
         $display("FAIL powerup_timing: got rel E%0d/E%0d/E%0d rdy E%0d, want E10/E14/E18 rdy E19",
                  first_bit[0], first_bit[1], first_bit[2], first_rdy);
      end else passed++;
   endtask

   task automatic test_lock_drop();
      int rel0;
      apply_reset();
      reset_n = 1'b1;
      for (int e = 1; e <= 11; e++) step(1'b1, 1'b0);
      for (int e = 12; e <= 14; e++) step(1'b0, 1'b0);
      step(1'b1, 1'b0);  // E15
      total++;
      if (rst_out_n !== 3'b000 || lock_loss_cnt !== 8'd1 || seq_state !== 3'd0 || sys_ready !== 1'b0) begin
         $display("FAIL lock_drop E15: got rst=%b cnt=%0d st=%0d rdy=%b, want rst=000 cnt=1 st=0 rdy=0",
                  rst_out_n, lock_loss_cnt, seq_state, sys_ready);
      end else passed++;
      rel0 = -1;
      for (int e = 16; e <= 35; e++) begin
         step(1'b1, 1'b0);
         total++;
         if ({rst_out_n, sys_ready, lock_loss_cnt, seq_state} !== {e_rst, e_rdy, e_cnt, e_seq}) begin
            $display("FAIL relock E%0d: got rst=%b rdy=%b cnt=%0d st=%0d, want rst=%b rdy=%b cnt=%0d st=%0d",
                     e, rst_out_n, sys_ready, lock_loss_cnt, seq_state, e_rst, e_rdy, e_cnt, e_seq);
         end else passed++;
         if (rst_out_n[0] && rel0 < 0) rel0 = e;
      end
      // pll high sampled at E15 -> lock_s seen at E17 -> 8 stable cycles -> E24
      total++;
      if (rel0 != 24) begin
         $display("FAIL relock_timing: got stage0 release E%0d, want E24", rel0);
      end else passed++;
   endtask

   task automatic test_sw_reset();
      int rel [N];
      logic [7:0] cnt_before;
      apply_reset();
      reset_n = 1'b1;
      for (int e = 1; e <= 20; e++) step(1'b1, 1'b0);
      cnt_before = lock_loss_cnt;
      step(1'b1, 1'b1);
      total++;
      if (rst_out_n !== 3'b000 || seq_state !== 3'd4 || sys_ready !== 1'b0) begin
         $display("FAIL sw_reset_enter: got rst=%b st=%0d rdy=%b, want rst=000 st=4 rdy=0",
                  rst_out_n, seq_state, sys_ready);
      end else passed++;
      for (int k = 0; k < N; k++) rel[k] = -1;
      for (int d = 1; d <= 14; d++) begin
         step(1'b1, 1'b0);
         total++;
         if ({rst_out_n, sys_ready, lock_loss_cnt, seq_state} !== {e_rst, e_rdy, e_cnt, e_seq}) begin
            $display("FAIL sw_reset +%0d: got rst=%b rdy=%b cnt=%0d st=%0d, want rst=%b rdy=%b cnt=%0d st=%0d",
                     d, rst_out_n, sys_ready, lock_loss_cnt, seq_state, e_rst, e_rdy, e_cnt, e_seq);
         end else passed++;
         for (int k = 0; k < N; k++) if (rst_out_n[k] && rel[k] < 0) rel[k] = d;
      end
      total++;
      if (rel[0] != 4 || rel[1] != 8 || rel[2] != 12 || lock_loss_cnt !== cnt_before) begin
         $display("FAIL sw_reset_timing: got +%0d/+%0d/+%0d cnt=%0d, want +4/+8/+12 cnt=%0d",
                  rel[0], rel[1], rel[2], lock_loss_cnt, cnt_before);
      end else passed++;
   endtask

   task automatic test_sw_and_loss();
      logic [7:0] cnt_before;
      for (int e = 0; e < 3; e++) step(1'b1, 1'b0);
      cnt_before = lock_loss_cnt;
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b1);  // lock_s seen low on the same edge as the request
      total++;
      if (seq_state !== 3'd0 || rst_out_n !== 3'b000 || lock_loss_cnt !== cnt_before + 8'd1) begin
         $display("FAIL sw_and_loss: got st=%0d rst=%b cnt=%0d, want st=0 rst=000 cnt=%0d",
                  seq_state, rst_out_n, lock_loss_cnt, cnt_before + 8'd1);
      end else passed++;
      sw_reset_req = 1'b0;
   endtask

   task automatic test_saturation();
      apply_reset();
      reset_n = 1'b1;
      for (int i = 0; i < 300; i++) begin
         step(1'b1, 1'b0);
         step(1'b0, 1'b0);
         if (i % 50 == 49) begin
            total++;
            if (lock_loss_cnt !== e_cnt) begin
               $display("FAIL sat_progress i%0d: got cnt=%0d, want %0d", i, lock_loss_cnt, e_cnt);
            end else passed++;
         end
      end
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
      total++;
      if (lock_loss_cnt !== 8'd255) begin
         $display("FAIL saturation: got cnt=%0d, want 255", lock_loss_cnt);
      end else passed++;
   endtask

   task automatic test_async_reset();
      for (int e = 0; e < 22; e++) step(1'b1, 1'b0);
      total++;
      if (rst_out_n !== 3'b111 || sys_ready !== 1'b1 || seq_state !== 3'd3) begin
         $display("FAIL pre_async_run: got rst=%b rdy=%b st=%0d, want rst=111 rdy=1 st=3",
                  rst_out_n, sys_ready, seq_state);
      end else passed++;
      #2;
      reset_n = 1'b0;
      #1;
      total++;
      if ({rst_out_n, sys_ready, lock_loss_cnt, seq_state} !== 15'd0) begin
         $display("FAIL async_reset: got rst=%b rdy=%b cnt=%0d st=%0d, want all 0",
                  rst_out_n, sys_ready, lock_loss_cnt, seq_state);
      end else passed++;
      model_reset();
      @(posedge clk); #1;
      reset_n = 1'b1;
   endtask

   task automatic test_random();
      logic pl, sw;
      apply_reset();
      reset_n = 1'b1;
      pl = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 23) == 0) pl = ~pl;
         sw = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 499) == 0) begin
            apply_reset();
            reset_n = 1'b1;
         end
         step(pl, sw);
         total++;
         if ({rst_out_n, sys_ready, lock_loss_cnt, seq_state} !== {e_rst, e_rdy, e_cnt, e_seq}) begin
            $display("FAIL random i%0d: got rst=%b rdy=%b cnt=%0d st=%0d, want rst=%b rdy=%b cnt=%0d st=%0d",
                     i, rst_out_n, sys_ready, lock_loss_cnt, seq_state, e_rst, e_rdy, e_cnt, e_seq);
         end else passed++;
      end
   endtask

   initial begin
      n = 0;
      model_reset();
      test_reset();
      test_powerup();
      test_lock_drop();
      test_sw_reset();
      test_sw_and_loss();
      test_saturation();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
